// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Optional auto-reload mode is selected with COUNTDOWN_AUTORELOAD_EN.
package countdown_timer_pkg;

  localparam int unsigned BCD_W       = 8;
  localparam int unsigned ALARM_CNT_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam bcd_t SEC_MAX = 8'h59;
  localparam bcd_t MIN_MAX = 8'h99;

  // A preset is usable only if every nibble is a decimal digit and seconds stay below 60.
  function automatic logic bcd_mmss_valid(input bcd_t mm, input bcd_t ss);
    return (mm[7:4] <= MIN_MAX[7:4]) && (mm[3:0] <= MIN_MAX[3:0]) &&
           (ss[7:4] <= SEC_MAX[7:4]) && (ss[3:0] <= MIN_MAX[3:0]);
  endfunction

  // Two-digit BCD decrement; caller guarantees the byte is nonzero.
  function automatic bcd_t bcd_dec_byte(input bcd_t b);
    if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
    else                return {b[7:4], b[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control, preset and status signals between the countdown timer and its environment.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic tick;
  logic tick_en;
  logic load;
  bcd_t preset_min;
  bcd_t preset_sec;
  logic start;
  logic pause;
  bcd_t min_bcd;
  bcd_t sec_bcd;
  logic running;
  logic done;
  logic alarm;
  logic load_err;

  modport master (
    output tick, load, preset_min, preset_sec, start, pause,
    input  tick_en, min_bcd, sec_bcd, running, done, alarm, load_err
  );

  modport slave (
    input  tick, load, preset_min, preset_sec, start, pause,
    output tick_en, min_bcd, sec_bcd, running, done, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer_bcd_dec_mmss.sv
// Combinational MM:SS BCD decrement by one second, saturating at 00:00.
module bcd_dec_mmss
  import countdown_timer_pkg::*;
(
  input  bcd_t min_bcd,
  input  bcd_t sec_bcd,
  output bcd_t min_dec,
  output bcd_t sec_dec,
  output logic zero
);

  always_comb begin
    min_dec = min_bcd;
    sec_dec = sec_bcd;
    if (sec_bcd == '0) begin
      // Borrow a minute; 00:00 stays put so the count never underflows.
      if (min_bcd != '0) begin
        sec_dec = SEC_MAX;
        min_dec = bcd_dec_byte(min_bcd);
      end
    end else begin
      sec_dec = bcd_dec_byte(sec_bcd);
    end
    zero = (min_dec == '0) && (sec_dec == '0);
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with load/start/pause control and a post-expiry alarm.
// Define COUNTDOWN_AUTORELOAD_EN to reload the stored preset on expiry instead of stopping.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_LEN = 4
) (
  input logic              clk,
  input logic              resetN,
  countdown_timer_if.slave bus
);

  localparam logic [ALARM_CNT_W-1:0] ALARM_LEN_C = ALARM_CNT_W'(ALARM_LEN);
  localparam logic [ALARM_CNT_W-1:0] ALARM_ONE   = ALARM_CNT_W'(1);

  state_e                 state, state_nxt;
  bcd_t                   cnt_min, cnt_min_nxt;
  bcd_t                   cnt_sec, cnt_sec_nxt;
  logic [ALARM_CNT_W-1:0] alarm_cnt, alarm_cnt_nxt;
  logic                   done, done_nxt;
  logic                   alarm, alarm_nxt;
  logic                   load_err, load_err_nxt;
  logic                   running, running_nxt;
  logic                   tick_en, tick_en_nxt;
`ifdef COUNTDOWN_AUTORELOAD_EN
  bcd_t                   store_min, store_min_nxt;
  bcd_t                   store_sec, store_sec_nxt;
`endif

  bcd_t dec_min;
  bcd_t dec_sec;
  logic dec_zero;
  logic cnt_zero;

  bcd_dec_mmss u_dec (
    .min_bcd (cnt_min),
    .sec_bcd (cnt_sec),
    .min_dec (dec_min),
    .sec_dec (dec_sec),
    .zero    (dec_zero)
  );

  assign cnt_zero = (cnt_min == '0) && (cnt_sec == '0);

  // Next-state and next-output logic; load outranks pause, which outranks start.
  always_comb begin
    state_nxt     = state;
    cnt_min_nxt   = cnt_min;
    cnt_sec_nxt   = cnt_sec;
    alarm_cnt_nxt = alarm_cnt;
    done_nxt      = done;
    alarm_nxt     = alarm;
    load_err_nxt  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    store_min_nxt = store_min;
    store_sec_nxt = store_sec;
`endif

    if (bus.load) begin
      // A malformed preset consumes the cycle without disturbing anything else.
      if (bcd_mmss_valid(bus.preset_min, bus.preset_sec)) begin
        cnt_min_nxt   = bus.preset_min;
        cnt_sec_nxt   = bus.preset_sec;
`ifdef COUNTDOWN_AUTORELOAD_EN
        store_min_nxt = bus.preset_min;
        store_sec_nxt = bus.preset_sec;
`endif
        state_nxt     = ST_IDLE;
        done_nxt      = 1'b0;
        alarm_nxt     = 1'b0;
        alarm_cnt_nxt = '0;
      end else begin
        load_err_nxt  = 1'b1;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.tick) begin
            cnt_min_nxt = dec_min;
            cnt_sec_nxt = dec_sec;
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (alarm_cnt != '0) begin
              alarm_cnt_nxt = alarm_cnt - ALARM_ONE;
              alarm_nxt     = (alarm_cnt != ALARM_ONE);
            end
            if (dec_zero) begin
              cnt_min_nxt   = store_min;
              cnt_sec_nxt   = store_sec;
              alarm_nxt     = 1'b1;
              alarm_cnt_nxt = ALARM_LEN_C;
            end
`else
            if (dec_zero) begin
              state_nxt     = ST_DONE;
              done_nxt      = 1'b1;
              alarm_nxt     = 1'b1;
              alarm_cnt_nxt = ALARM_LEN_C;
            end
`endif
          end
          // The tick above still lands; expiry into DONE takes precedence over pause.
          if (bus.pause && (state_nxt == ST_RUN)) state_nxt = ST_PAUSE;
        end
        ST_IDLE, ST_PAUSE: begin
          if (bus.start && !cnt_zero) state_nxt = ST_RUN;
        end
        ST_DONE: begin
          if (bus.tick && (alarm_cnt != '0)) begin
            alarm_cnt_nxt = alarm_cnt - ALARM_ONE;
            alarm_nxt     = (alarm_cnt != ALARM_ONE);
          end
        end
      endcase
    end

    running_nxt = (state_nxt == ST_RUN);
    tick_en_nxt = running_nxt || ((state_nxt == ST_DONE) && alarm_nxt);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      cnt_min   <= '0;
      cnt_sec   <= '0;
      alarm_cnt <= '0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      load_err  <= 1'b0;
      running   <= 1'b0;
      tick_en   <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      store_min <= '0;
      store_sec <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt_min   <= cnt_min_nxt;
      cnt_sec   <= cnt_sec_nxt;
      alarm_cnt <= alarm_cnt_nxt;
      done      <= done_nxt;
      alarm     <= alarm_nxt;
      load_err  <= load_err_nxt;
      running   <= running_nxt;
      tick_en   <= tick_en_nxt;
`ifdef COUNTDOWN_AUTORELOAD_EN
      store_min <= store_min_nxt;
      store_sec <= store_sec_nxt;
`endif
    end
  end

  assign bus.min_bcd  = cnt_min;
  assign bus.sec_bcd  = cnt_sec;
  assign bus.running  = running;
  assign bus.done     = done;
  assign bus.alarm    = alarm;
  assign bus.load_err = load_err;
  assign bus.tick_en  = tick_en;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter ALARM_LEN, default 4, number of ticks for which alarm stays high after expiry (1..15).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz).
REQ-003 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tick  input  1  one-cycle one-second pulse from the upstream tick generator.
REQ-005 SHALL have port tick_en  output  1  enable driven back to the tick generator.
REQ-006 SHALL have port load  input  1  one-cycle pulse; captures preset.
REQ-007 SHALL have port preset_min  input  8  BCD minutes, 00..99.
REQ-008 SHALL have port preset_sec  input  8  BCD seconds, 00..59.
REQ-009 SHALL have port start  input  1  one-cycle pulse; begin or resume countdown.
REQ-010 SHALL have port pause  input  1  one-cycle pulse; freeze countdown.
REQ-011 SHALL have ports min_bcd / sec_bcd  output  8 each  current count in BCD.
REQ-012 SHALL have ports running, done, alarm, load_err  output  1 each  status flags.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE; running is high only in RUN.
REQ-014 tick_en SHALL be high in RUN, and in DONE while alarm is high; low otherwise.
REQ-015 load SHALL be accepted in any state and SHALL copy preset into count and the preset store, go to IDLE, and clear done and alarm on the next edge.
REQ-016 load with any BCD nibble >9, or preset_sec tens >5, SHALL be rejected: count, store and state unchanged; load_err high for exactly one cycle.
REQ-017 start SHALL move IDLE or PAUSE to RUN only if count is nonzero; otherwise it is ignored.
REQ-018 pause SHALL move RUN to PAUSE; it is ignored in other states.
REQ-019 In RUN, each tick SHALL decrement the count by one second in BCD, with borrow sec 00 -> 59 and min decremented; the new value is visible one cycle after tick.
REQ-020 A tick that decrements 00:01 to 00:00 SHALL move RUN to DONE, set done and alarm on the same edge, and load the alarm counter with ALARM_LEN.
REQ-021 In DONE, each tick SHALL decrement the alarm counter; alarm SHALL drop on the edge where the counter reaches 0; done SHALL stay high until load or reset.
REQ-022 Ticks SHALL be ignored in IDLE and PAUSE.
REQ-023 Same-cycle priority SHALL be: load > pause > start; a tick coinciding with pause SHALL still decrement before entering PAUSE.
REQ-024 Count SHALL never underflow below 00:00 and SHALL never exceed 99:59.

Reset
REQ-025 resetN low SHALL asynchronously force state IDLE, count and preset store 00:00, alarm counter 0, and all outputs 0.
REQ-026 Reset mid-RUN or mid-alarm SHALL take effect immediately; after reset release, start with count 00:00 SHALL be ignored.

Configuration
REQ-027 Macro COUNTDOWN_AUTORELOAD_EN SHALL select auto-reload mode.
REQ-028 With COUNTDOWN_AUTORELOAD_EN defined, reaching 00:00 SHALL reload the stored preset on the same edge, stay in RUN, raise alarm for ALARM_LEN ticks, and keep done low.
REQ-029 Without COUNTDOWN_AUTORELOAD_EN, behaviour SHALL be as REQ-020/021.

Structure
REQ-030 Package countdown_timer_pkg SHALL hold the state enum, the BCD byte typedef, and constants SEC_MAX (8'h59) and MIN_MAX (8'h99).
REQ-031 Sub-module bcd_dec_mmss SHALL hold the combinational MM:SS BCD decrement with borrow and a zero flag.

Verification
REQ-032 Load 01:00, start, 1 tick -> 00:59 one cycle later; 60 ticks total -> 00:00, done=1, alarm=1.
REQ-033 Expiry with ALARM_LEN=4 -> alarm high for exactly 4 subsequent ticks, then low; done stays 1; tick_en drops with alarm.
REQ-034 Load preset_sec=8'h6A -> load_err one-cycle pulse; count unchanged.
REQ-035 Count 00:10 in RUN, pause and tick in same cycle -> 00:09, state PAUSE; 5 further ticks -> still 00:09.
REQ-036 load, start and tick in the same cycle -> preset captured, state IDLE, no decrement.
REQ-037 With COUNTDOWN_AUTORELOAD_EN, preset 00:03, 3 ticks -> count 00:03, running=1, alarm=1, done=0.
